// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle control FSM for the RISC_1 core.
// Steps IDLE -> FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH, latching the
// opcode (instr[31:25]) in FETCH and driving operand-select, PC, IR, data-memory
// and register-file controls as a Moore function of state and latched opcode.
//
// Optional feature: define EXEC_WATCHDOG_EN to abort a MEM wait after
// MEM_TIMEOUT cycles with mem_ready low (sets sticky timeout_err).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           leave IDLE (ignored elsewhere)
//   instr[31:0]     instruction word, opcode sampled in FETCH
//   mem_ready       data-memory completion, sampled in MEM
//   ir_load, pc_inc, pc_load                 IR / PC strobes
//   aluSrc, memRead, branch, aluOp[6:0]      operand-decider controls
//   memWrite, mem_req                        data-memory controls
//   regWrite                                 register-file write enable
//   busy, halted                             status
//   retired[RETIRE_W-1:0]                    completed-instruction count
//   timeout_err                              sticky MEM-timeout flag
module exec_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [31:0]         instr,
  input  logic                mem_ready,
  output logic                ir_load,
  output logic                pc_inc,
  output logic                pc_load,
  output logic                aluSrc,
  output logic                memRead,
  output logic                memWrite,
  output logic                mem_req,
  output logic                branch,
  output logic                regWrite,
  output logic [6:0]          aluOp,
  output logic                busy,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired,
  output logic                timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b1000000;
  localparam logic [6:0] OP_SW    = 7'b1000001;
  localparam logic [6:0] OP_HALT  = 7'b1111111;
  localparam logic [6:0] SW_ALUOP = 7'b0110001;

  state_t     state, state_nxt;
  logic [6:0] op;
  logic       is_itype, is_lw, is_sw, is_halt, is_jump;
  logic [6:0] exec_op;
  logic       retire;
  logic       wd_fire;
  logic       unused_instr;

  assign unused_instr = ^instr[24:0];

  always_comb begin
    is_itype = op inside {7'b0000100, 7'b0000101, 7'b0100000, 7'b0100001, 7'b0100100};
    is_lw    = (op == OP_LW);
    is_sw    = (op == OP_SW);
    is_halt  = (op == OP_HALT);
    is_jump  = (op[6:5] == 2'b11) && !is_halt;
    // Stores present the address-offset operation so the decider picks the offset.
    exec_op  = is_sw ? SW_ALUOP : op;
  end

`ifdef EXEC_WATCHDOG_EN
  localparam int unsigned WD_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  // Fires on the stall cycle that brings the count up to MEM_TIMEOUT;
  // mem_ready in that same cycle takes priority.
  assign wd_fire     = (state == S_MEM) && !mem_ready && (wd_cnt == WD_W'(MEM_TIMEOUT - 1));
  assign timeout_err = timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      // MEM is only entered from EXEC, so clearing in EXEC restarts each wait.
      if (state == S_EXEC)
        wd_cnt <= '0;
      else if (state == S_MEM && !mem_ready)
        wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_fire)
        timeout_q <= 1'b1;
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op      <= '0;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH)
        op <= instr[31:25];
      if (retire)
        retired <= retired + RETIRE_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    aluSrc    = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    mem_req   = 1'b0;
    branch    = 1'b0;
    regWrite  = 1'b0;
    aluOp     = '0;
    retire    = 1'b0;
    busy      = (state != S_IDLE) && (state != S_HALT);
    halted    = (state == S_HALT);
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        ir_load   = 1'b1;
        pc_inc    = 1'b1;
        state_nxt = S_DECODE;
      end
      S_DECODE: begin
        state_nxt = is_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        aluOp   = exec_op;
        aluSrc  = is_itype;
        memRead = is_lw;
        branch  = is_jump;
        pc_load = is_jump;
        if (is_jump) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        aluOp    = exec_op;
        mem_req  = 1'b1;
        memRead  = is_lw;
        memWrite = is_sw;
        if (mem_ready) begin
          retire    = is_sw;
          state_nxt = is_lw ? S_WB : S_FETCH;
        end else if (wd_fire) begin
          state_nxt = S_FETCH;
        end
      end
      S_WB: begin
        regWrite  = 1'b1;
        aluOp     = op;
        aluSrc    = is_itype;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: a per-cycle vector table covering the
// instruction classes, MEM waits, HALT and reset, followed by hand-written
// sequences for the long MEM stall (watchdog abort or indefinite wait).
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, mem_ready;
  logic [31:0] instr;
  logic        ir_load, pc_inc, pc_load, aluSrc, memRead, memWrite, mem_req;
  logic        branch, regWrite, busy, halted, timeout_err;
  logic [6:0]  aluOp;
  logic [31:0] retired;

  int unsigned checks = 0;
  int unsigned errors = 0;

  exec_sequencer #(.MEM_TIMEOUT(16), .RETIRE_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .instr(instr), .mem_ready(mem_ready),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .aluSrc(aluSrc),
    .memRead(memRead), .memWrite(memWrite), .mem_req(mem_req), .branch(branch),
    .regWrite(regWrite), .aluOp(aluOp), .busy(busy), .halted(halted),
    .retired(retired), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  typedef struct {
    logic        rst, start, mr;
    logic [31:0] instr;
    logic [10:0] ctl;   // {ir_load,pc_inc,pc_load,aluSrc,memRead,memWrite,mem_req,branch,regWrite,busy,halted}
    logic [6:0]  aop;
    int unsigned ret;
  } vec_t;

  localparam logic [10:0] K_IDLE   = 11'b000_0000_0000;
  localparam logic [10:0] K_FETCH  = 11'b110_0000_0010;
  localparam logic [10:0] K_DEC    = 11'b000_0000_0010;
  localparam logic [10:0] K_EX_R   = 11'b000_0000_0010;
  localparam logic [10:0] K_EX_I   = 11'b000_1000_0010;
  localparam logic [10:0] K_EX_LW  = 11'b000_0100_0010;
  localparam logic [10:0] K_EX_J   = 11'b001_0000_1010;
  localparam logic [10:0] K_MEM_LW = 11'b000_0101_0010;
  localparam logic [10:0] K_MEM_SW = 11'b000_0011_0010;
  localparam logic [10:0] K_WB     = 11'b000_0000_0110;
  localparam logic [10:0] K_WB_I   = 11'b000_1000_0110;
  localparam logic [10:0] K_HALT   = 11'b000_0000_0001;

  localparam logic [31:0] I_ADDI  = 32'h0800_0000;  // op 0000100
  localparam logic [31:0] I_LW    = 32'h8000_0000;  // op 1000000
  localparam logic [31:0] I_SW    = 32'h8200_0000;  // op 1000001
  localparam logic [31:0] I_R     = 32'h6600_0000;  // op 0110011
  localparam logic [31:0] I_JMP   = 32'hC000_0000;  // op 1100000
  localparam logic [31:0] I_HALT  = 32'hFE00_0000;  // op 1111111
  localparam logic [31:0] NOISE   = 32'hFFFF_FFFF;  // must not be latched outside FETCH

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic m, logic [31:0] i,
                              logic [10:0] c, logic [6:0] a, int unsigned rt);
    vec_t v;
    v.rst = r; v.start = s; v.mr = m; v.instr = i; v.ctl = c; v.aop = a; v.ret = rt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] ctl_now();
    return {ir_load, pc_inc, pc_load, aluSrc, memRead, memWrite, mem_req,
            branch, regWrite, busy, halted};
  endfunction

  initial begin
    int unsigned n;
    // reset / start-during-reset
    vecs.push_back(mk(1, 1, 0, NOISE,  K_IDLE,   7'h00, 0));
    vecs.push_back(mk(0, 0, 0, NOISE,  K_IDLE,   7'h00, 0));
    vecs.push_back(mk(0, 1, 0, NOISE,  K_IDLE,   7'h00, 0));
    // addi
    vecs.push_back(mk(0, 0, 0, I_ADDI, K_FETCH,  7'h00, 0));
    vecs.push_back(mk(0, 1, 0, NOISE,  K_DEC,    7'h00, 0));
    vecs.push_back(mk(0, 0, 0, NOISE,  K_EX_I,   7'b0000100, 0));
    vecs.push_back(mk(0, 0, 0, NOISE,  K_WB_I,   7'b0000100, 0));
    // LW with two wait cycles
    vecs.push_back(mk(0, 0, 0, I_LW,   K_FETCH,  7'h00, 1));
    vecs.push_back(mk(0, 0, 0, NOISE,  K_DEC,    7'h00, 1));
    vecs.push_back(mk(0, 0, 0, NOISE,  K_EX_LW,  7'b1000000, 1));
    vecs.push_back(mk(0, 0, 0, NOISE,  K_MEM_LW, 7'b1000000, 1));
    vecs.push_back(mk(0, 0, 0, NOISE,  K_MEM_LW, 7'b1000000, 1));
    vecs.push_back(mk(0, 0, 1, NOISE,  K_MEM_LW, 7'b1000000, 1));
    vecs.push_back(mk(0, 0, 0, NOISE,  K_WB,     7'b1000000, 1));
    // SW, ready immediately (ready during EXEC is ignored)
    vecs.push_back(mk(0, 0, 0, I_SW,   K_FETCH,  7'h00, 2));
    vecs.push_back(mk(0, 0, 0, NOISE,  K_DEC,    7'h00, 2));
    vecs.push_back(mk(0, 0, 1, NOISE,  K_EX_R,   7'b0110001, 2));
    vecs.push_back(mk(0, 0, 1, NOISE,  K_MEM_SW, 7'b0110001, 2));
    // R-type
    vecs.push_back(mk(0, 0, 0, I_R,    K_FETCH,  7'h00, 3));
    vecs.push_back(mk(0, 0, 0, NOISE,  K_DEC,    7'h00, 3));
    vecs.push_back(mk(0, 0, 0, NOISE,  K_EX_R,   7'b0110011, 3));
    vecs.push_back(mk(0, 0, 0, NOISE,  K_WB,     7'b0110011, 3));
    // JUMP
    vecs.push_back(mk(0, 0, 0, I_JMP,  K_FETCH,  7'h00, 4));
    vecs.push_back(mk(0, 0, 0, NOISE,  K_DEC,    7'h00, 4));
    vecs.push_back(mk(0, 0, 0, NOISE,  K_EX_J,   7'b1100000, 4));
    // SW with one wait cycle
    vecs.push_back(mk(0, 0, 0, I_SW,   K_FETCH,  7'h00, 5));
    vecs.push_back(mk(0, 0, 0, NOISE,  K_DEC,    7'h00, 5));
    vecs.push_back(mk(0, 0, 0, NOISE,  K_EX_R,   7'b0110001, 5));
    vecs.push_back(mk(0, 0, 0, NOISE,  K_MEM_SW, 7'b0110001, 5));
    vecs.push_back(mk(0, 0, 1, NOISE,  K_MEM_SW, 7'b0110001, 5));
    // HALT absorbs, start ignored
    vecs.push_back(mk(0, 0, 0, I_HALT, K_FETCH,  7'h00, 6));
    vecs.push_back(mk(0, 0, 0, NOISE,  K_DEC,    7'h00, 6));
    vecs.push_back(mk(0, 1, 0, NOISE,  K_HALT,   7'h00, 6));
    vecs.push_back(mk(0, 1, 1, NOISE,  K_HALT,   7'h00, 6));
    vecs.push_back(mk(1, 0, 0, NOISE,  K_HALT,   7'h00, 6));
    // reset during LW MEM wait
    vecs.push_back(mk(0, 1, 0, NOISE,  K_IDLE,   7'h00, 0));
    vecs.push_back(mk(0, 0, 0, I_LW,   K_FETCH,  7'h00, 0));
    vecs.push_back(mk(0, 0, 0, NOISE,  K_DEC,    7'h00, 0));
    vecs.push_back(mk(0, 0, 0, NOISE,  K_EX_LW,  7'b1000000, 0));
    vecs.push_back(mk(1, 0, 0, NOISE,  K_MEM_LW, 7'b1000000, 0));
    vecs.push_back(mk(0, 0, 0, NOISE,  K_IDLE,   7'h00, 0));

    rst = 1'b1; start = 1'b0; mem_ready = 1'b0; instr = NOISE;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; start = vecs[i].start; mem_ready = vecs[i].mr; instr = vecs[i].instr;
      #1;
      chk($sformatf("row%0d ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
      chk($sformatf("row%0d aluOp", i), 32'(aluOp), 32'(vecs[i].aop));
      chk($sformatf("row%0d retired", i), retired, vecs[i].ret);
      chk($sformatf("row%0d timeout_err", i), 32'(timeout_err), 32'd0);
    end

    // Long LW stall from IDLE
    @(negedge clk); start = 1'b1; mem_ready = 1'b0;
    @(negedge clk); start = 1'b0; instr = I_LW;
    chk("stall fetch", 32'(ir_load), 32'd1);
    @(negedge clk); instr = NOISE;
    @(negedge clk);
    chk("stall exec memRead", 32'(memRead), 32'd1);
    @(negedge clk);
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      @(negedge clk);
    end
`ifdef EXEC_WATCHDOG_EN
    chk("wd mem cycles", n, 32'd16);
    chk("wd back to fetch", 32'(ir_load), 32'd1);
    chk("wd timeout_err", 32'(timeout_err), 32'd1);
    chk("wd retired unchanged", retired, 32'd0);
    chk("wd no regWrite", 32'(regWrite), 32'd0);
    instr = I_R;
    @(negedge clk); instr = NOISE;
    @(negedge clk);
    @(negedge clk);
    chk("wd next wb", 32'(regWrite), 32'd1);
    @(negedge clk);
    chk("wd next retired", retired, 32'd1);
    chk("wd sticky", 32'(timeout_err), 32'd1);
`else
    chk("nowd still mem", n, 32'd40);
    chk("nowd mem_req", 32'(mem_req), 32'd1);
    chk("nowd timeout_err", 32'(timeout_err), 32'd0);
    mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    chk("nowd wb", 32'(regWrite), 32'd1);
    chk("nowd wb retired", retired, 32'd0);
    @(negedge clk);
    chk("nowd fetch", 32'(ir_load), 32'd1);
    chk("nowd retired", retired, 32'd1);
`endif
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("final rst timeout_err", 32'(timeout_err), 32'd0);
    chk("final rst retired", retired, 32'd0);
    chk("final rst ctl", 32'(ctl_now()), 32'(K_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
